core_seqctl: RTL
================

// Module: core_seqctl
// PURPOSE
// - Opcode sequencer sitting directly upstream of alureg in the 8085-style core.
// - Accepts opcode/immediate bytes from the fetch path over a valid/ready handshake.
// - Classifies MOV/MVI/ALU/HLT and drives alureg's code, data, read and write strobes.
// - Strobes follow alureg's required order: code latch, data latch, reg read, reg read+write.
// PARAMETERS
// - MYSIZE  8   data/opcode width
// - CNTBIT  16  retired-instruction counter width (SEQCTL_ICNT_EN only)
// PORTS
// - clk    in   1       core clock, rising edge
// - rstn   in   1       asynchronous active-low reset
// - iDAT   in   MYSIZE  byte from fetch path
// - iVLD   in   1       iDAT valid
// - oRDY   out  1       sequencer accepts a byte; transfer = iVLD & oRDY at rising edge
// - oDAT   out  MYSIZE  held byte to alureg iDAT
// - oENC   out  1       alureg code-latch strobe
// - oEND   out  1       alureg data-latch strobe
// - oRRD   out  1       alureg register-read strobe
// - oRWR   out  1       alureg register-write strobe
// - oDONE  out  1       one-cycle pulse, instruction retired
// - oERR   out  1       one-cycle pulse, unsupported opcode dropped
// - oHALT  out  1       level, halted
// BEHAVIOUR
// - Reset: all outputs 0, oDAT=0, state IDLE. Async assert aborts any instruction immediately, even mid-sequence.
// - Outputs are Moore: decoded from the state register only; oDAT is a register.
// - Decode on the latched opcode:
//   - {01,ddd,sss}, sss!=110: MOV.
//   - {01,ddd,110}: MVI. Exception: 8'h76 is HLT.
//   - {10,ooo,sss}, sss!=110: ALU reg.
//   - {10,ooo,110}: ALU imm.
//   - 00xxxxxx, 11xxxxxx: unsupported.
// - States:
//   - IDLE: oRDY=1. On transfer: oDAT<=iDAT, go ENC.
//   - ENC: oENC=1. Next state by opcode class:
//     - MVI / ALU imm: go WDAT.
//     - MOV / ALU reg: go RRD.
//     - HLT: go HALT.
//     - Unsupported: go ERR.
//   - WDAT: oRDY=1. Waits indefinitely for iVLD. On transfer: oDAT<=iDAT, go END.
//   - END: oEND=1, go RRD.
//   - RRD: oRRD=1, go RWR.
//   - RWR: oRRD=1 and oRWR=1 (read held through write), go DONE.
//   - DONE: oDONE=1, go IDLE.
//   - ERR: oERR=1, go IDLE. No alureg strobe besides the earlier oENC.
//   - HALT: oHALT=1, oRDY=0. Left only by reset.
// - Latency from opcode transfer edge (no-wait data):
//   - MOV / ALU reg: oENC at cycle 1, oRRD at cycles 2-3, oRWR at cycle 3, oDONE at cycle 4, oRDY at cycle 5.
//   - MVI / ALU imm: oRDY in WDAT at cycle 2, oEND at cycle 3, oDONE at cycle 6.
// - Hold rules:
//   - iVLD while oRDY=0 is ignored; the source must hold the byte.
//   - oDAT holds its value between transfers.
//   - At most one strobe among oENC/oEND is high in any cycle.
// CONFIGURATION
// - SEQCTL_ICNT_EN defined:
//   - Adds output oICNT [CNTBIT-1:0], reset 0.
//   - Increments in the cycle after each oDONE; wraps from all-ones to 0.
//   - Not incremented on ERR or HLT.
// - SEQCTL_ICNT_EN undefined: no oICNT port and no counter logic.
// TESTING
// - MVI A: opcode 8'h7E then data 8'hAA, both back-to-back valid.
//   -> Strobe order is oENC, oEND (oDAT=AA), oRRD, oRRD+oRWR, oDONE.
//   -> After the sequence, alureg reg A=AA.
// - MOV B,A: opcode 8'h47.
//   -> No oEND; oDONE 4 cycles after transfer.
//   -> After the sequence, reg B=AA.
// - XRA A: opcode 8'hAF.
//   -> ALU reg path; after oDONE, A=00.
//   -> Then MOV C,A (8'h4F): C=00.
// - Data stall: 8'h3E-class MVI (8'h7E) with iVLD low for 5 cycles in WDAT.
//   -> oRDY stays 1 and no strobes fire.
//   -> oEND follows the transfer by 1 cycle.
// - Unsupported: 8'h00.
//   -> oENC, then oERR one cycle; oDONE stays 0; back in IDLE (oRDY=1).
//   - With SEQCTL_ICNT_EN: oICNT is unchanged.
// - HLT / reset:
//   - 8'h76 -> oHALT=1; a later iVLD is ignored.
//   - rstn low mid-MVI (in END) -> all outputs 0 at once; after release, state is IDLE with oRDY=1.

Source files
------------

// File: rtl/core_seqctl_if.sv
// rtl/core_seqctl_if.sv - fetch-side handshake and alureg strobe bundle for core_seqctl
// oICNT exists only when SEQCTL_ICNT_EN is defined.
interface core_seqctl_if #(
    parameter int MYSIZE = 8
`ifdef SEQCTL_ICNT_EN
    , parameter int CNTBIT = 16
`endif
);
    logic [MYSIZE-1:0] iDAT;
    logic              iVLD;
    logic              oRDY;
    logic [MYSIZE-1:0] oDAT;
    logic              oENC;
    logic              oEND;
    logic              oRRD;
    logic              oRWR;
    logic              oDONE;
    logic              oERR;
    logic              oHALT;
`ifdef SEQCTL_ICNT_EN
    logic [CNTBIT-1:0] oICNT;
`endif

    modport slave (
        input  iDAT, iVLD,
        output oRDY, oDAT, oENC, oEND, oRRD, oRWR, oDONE, oERR, oHALT
`ifdef SEQCTL_ICNT_EN
        , output oICNT
`endif
    );

    modport master (
        output iDAT, iVLD,
        input  oRDY, oDAT, oENC, oEND, oRRD, oRWR, oDONE, oERR, oHALT
`ifdef SEQCTL_ICNT_EN
        , input oICNT
`endif
    );
endinterface

// File: rtl/core_seqctl.sv
// rtl/core_seqctl.sv - opcode sequencer driving alureg code/data/read/write strobes
// SEQCTL_ICNT_EN adds the retired-instruction counter oICNT.
module core_seqctl #(
    parameter int MYSIZE = 8
`ifdef SEQCTL_ICNT_EN
    , parameter int CNTBIT = 16
`endif
) (
    input  logic          clk,
    input  logic          rstn,
    core_seqctl_if.slave  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_ENC, S_WDAT, S_END, S_RRD, S_RWR, S_DONE, S_ERR, S_HALT
    } state_t;

    typedef enum logic [1:0] {
        C_REG, C_IMM, C_HLT, C_BAD
    } cls_t;

    state_t            state_q, state_d;
    logic [MYSIZE-1:0] dat_q, dat_d;
    logic              run_q, run_d;
    cls_t              cls;
    logic              rdy;
    logic              xfer;

    // run_q keeps oRDY low while reset is held, so every output reads 0 in reset.
    assign rdy  = run_q & ((state_q == S_IDLE) | (state_q == S_WDAT));
    assign xfer = rdy & bus.iVLD;
    assign run_d = 1'b1;

    always_comb begin
        cls = C_BAD;
        case (dat_q[7:6])
            2'b01: begin
                if (dat_q[7:0] == 8'h76)
                    cls = C_HLT;
                else if (dat_q[2:0] == 3'b110)
                    cls = C_IMM;
                else
                    cls = C_REG;
            end
            2'b10: cls = (dat_q[2:0] == 3'b110) ? C_IMM : C_REG;
            default: cls = C_BAD;
        endcase
    end

    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    dat_d   = bus.iDAT;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                case (cls)
                    C_IMM:   state_d = S_WDAT;
                    C_REG:   state_d = S_RRD;
                    C_HLT:   state_d = S_HALT;
                    default: state_d = S_ERR;
                endcase
            end
            S_WDAT: begin
                if (xfer) begin
                    dat_d   = bus.iDAT;
                    state_d = S_END;
                end
            end
            S_END:   state_d = S_RRD;
            S_RRD:   state_d = S_RWR;
            S_RWR:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            dat_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            run_q   <= run_d;
        end
    end

    assign bus.oRDY  = rdy;
    assign bus.oDAT  = dat_q;
    assign bus.oENC  = (state_q == S_ENC);
    assign bus.oEND  = (state_q == S_END);
    // Register read stays asserted through the write cycle.
    assign bus.oRRD  = (state_q == S_RRD) | (state_q == S_RWR);
    assign bus.oRWR  = (state_q == S_RWR);
    assign bus.oDONE = (state_q == S_DONE);
    assign bus.oERR  = (state_q == S_ERR);
    assign bus.oHALT = (state_q == S_HALT);

`ifdef SEQCTL_ICNT_EN
    logic [CNTBIT-1:0] icnt_q, icnt_d;

    always_comb begin
        icnt_d = icnt_q;
        if (state_q == S_DONE)
            icnt_d = icnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            icnt_q <= '0;
        else
            icnt_q <= icnt_d;
    end

    assign bus.oICNT = icnt_q;
`endif

endmodule
